// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shifter_pipe
//  Description : Pipelined WIDTH-bit barrel shifter (LSL/LSR/ASR/ROL).
//                One registered mux layer per shift-amount bit, largest
//                shift first. Valid/ready flow control with bubble collapse.
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] c_op_lsl = 2'b00;
  localparam logic [1:0] c_op_lsr = 2'b01;
  localparam logic [1:0] c_op_asr = 2'b10;

  logic [LOG2W-1:0] r_v;
  logic [WIDTH-1:0] r_data [LOG2W];
  logic [LOG2W-1:0] r_amt  [LOG2W];
  logic [1:0]       r_op   [LOG2W];
  logic [TAG_W-1:0] r_tag  [LOG2W];

  logic [LOG2W-1:0] w_adv;
  logic [LOG2W-1:0] w_src_v;
  logic [WIDTH-1:0] w_src_d [LOG2W];
  logic [LOG2W-1:0] w_src_a [LOG2W];
  logic [1:0]       w_src_o [LOG2W];
  logic [TAG_W-1:0] w_src_t [LOG2W];
  logic [WIDTH-1:0] w_sh    [LOG2W];

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d,
                                               input logic [1:0] op,
                                               input int k);
    logic [WIDTH-1:0] res;
    case (op)
      c_op_lsl: res = d << k;
      c_op_lsr: res = d >> k;
      c_op_asr: res = $unsigned($signed(d) >>> k);
      default:  res = (d << k) | (d >> (WIDTH - k));
    endcase
    return res;
  endfunction

  // Ready chain: a stage may hand on its contents when the next one is empty or moving.
  always_comb begin
    w_adv = '0;
    w_adv[LOG2W-1] = out_ready;
    for (int s = LOG2W - 2; s >= 0; s--) begin
      w_adv[s] = !r_v[s+1] || w_adv[s+1];
    end
  end

  always_comb begin
    w_src_v    = '0;
    w_src_v[0] = in_valid;
    w_src_d[0] = in_data;
    w_src_a[0] = in_amt;
    w_src_o[0] = in_op;
    w_src_t[0] = in_tag;
    for (int s = 1; s < LOG2W; s++) begin
      w_src_v[s] = r_v[s-1];
      w_src_d[s] = r_data[s-1];
      w_src_a[s] = r_amt[s-1];
      w_src_o[s] = r_op[s-1];
      w_src_t[s] = r_tag[s-1];
    end
    for (int s = 0; s < LOG2W; s++) begin
      w_sh[s] = w_src_a[s][LOG2W-1-s] ? f_shift(w_src_d[s], w_src_o[s], 1 << (LOG2W - 1 - s))
                                      : w_src_d[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int s = 0; s < LOG2W; s++) begin
        r_data[s] <= '0;
        r_amt[s]  <= '0;
        r_op[s]   <= '0;
        r_tag[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < LOG2W; s++) begin
        if (!r_v[s] || w_adv[s]) begin
          r_v[s] <= w_src_v[s];
          // Payload only moves with a real operation; bubbles leave it untouched.
          if (w_src_v[s]) begin
            r_data[s] <= w_sh[s];
            r_amt[s]  <= w_src_a[s];
            r_op[s]   <= w_src_o[s];
            r_tag[s]  <= w_src_t[s];
          end
        end
      end
    end
  end

  assign in_ready  = !r_v[0] || w_adv[0];
  assign out_valid = r_v[LOG2W-1];
  assign out_data  = r_data[LOG2W-1];
  assign out_tag   = r_tag[LOG2W-1];
  assign out_zero  = ~|r_data[LOG2W-1];

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrel_shifter_pipe
//  Description : Scoreboard bench for barrel_shifter_pipe (WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_amt = '0;
  logic [1:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_zero;
  logic [3:0]  out_tag;

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic stall_chk = 1'b0;

  barrel_shifter_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops on every output transfer; during a stall the head must already be presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {16'h0, out_data}, 32'hFFFF_FFFF);
      end else if (out_ready) begin
        exp_t e;
        e = q.pop_front();
        chk("result_data", {16'h0, out_data}, {16'h0, e.data});
        chk("result_tag",  {28'h0, out_tag},  {28'h0, e.tag});
        chk("result_zero", {31'h0, out_zero}, {31'h0, (e.data == 16'h0)});
      end else if (stall_chk) begin
        chk("stall_data", {16'h0, out_data}, {16'h0, q[0].data});
        chk("stall_tag",  {28'h0, out_tag},  {28'h0, q[0].tag});
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] amt,
                      input logic [3:0] tag, input logic [15:0] e);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_data = d;
    in_amt = amt;
    in_tag = tag;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) q.push_back({tag, e});
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_data = 16'hDEAD;
    in_amt = 4'hF;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", q.size(), 32'd0);
  endtask

  logic [1:0]  t_op  [8];
  logic [15:0] t_d   [8];
  logic [3:0]  t_amt [8];
  logic [15:0] t_exp [8];

  initial begin
    int n;
    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'h0, out_data},  32'd0);
    chk("rst_out_tag",   {28'h0, out_tag},   32'd0);
    chk("rst_out_zero",  {31'h0, out_zero},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: latency, counting the accept edge as the first registered edge
    send(2'b00, 16'h00FF, 4'd4, 4'd1, 16'h0FF0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t1_latency", n, 32'd4);
    drain();

    // 2-4: directed vectors, back-to-back
    send(2'b10, 16'h8000, 4'd15, 4'd2, 16'hFFFF);
    send(2'b01, 16'h8000, 4'd15, 4'd3, 16'h0001);
    send(2'b10, 16'h4000, 4'd2,  4'd4, 16'h1000);
    send(2'b11, 16'h8001, 4'd1,  4'd5, 16'h0003);
    send(2'b11, 16'h8001, 4'd0,  4'd6, 16'h8001);
    send(2'b11, 16'h1234, 4'd8,  4'd7, 16'h3412);
    send(2'b00, 16'h8000, 4'd1,  4'd8, 16'h0000);
    send(2'b00, 16'h0001, 4'd15, 4'd9, 16'h8000);
    send(2'b01, 16'h00F0, 4'd4,  4'hA, 16'h000F);
    send(2'b10, 16'h8421, 4'd5,  4'hB, 16'hFC21);
    drain();

    // 5: backpressure mid-stream
    t_op[0] = 2'b00; t_d[0] = 16'h0001; t_amt[0] = 4'd0; t_exp[0] = 16'h0001;
    t_op[1] = 2'b01; t_d[1] = 16'h8000; t_amt[1] = 4'd1; t_exp[1] = 16'h4000;
    t_op[2] = 2'b10; t_d[2] = 16'h8000; t_amt[2] = 4'd2; t_exp[2] = 16'hE000;
    t_op[3] = 2'b11; t_d[3] = 16'h8001; t_amt[3] = 4'd3; t_exp[3] = 16'h000C;
    t_op[4] = 2'b00; t_d[4] = 16'h00FF; t_amt[4] = 4'd4; t_exp[4] = 16'h0FF0;
    t_op[5] = 2'b01; t_d[5] = 16'hFFFF; t_amt[5] = 4'd5; t_exp[5] = 16'h07FF;
    t_op[6] = 2'b10; t_d[6] = 16'h7FFF; t_amt[6] = 4'd6; t_exp[6] = 16'h01FF;
    t_op[7] = 2'b11; t_d[7] = 16'h1234; t_amt[7] = 4'd7; t_exp[7] = 16'h1A09;
    for (int i = 0; i < 3; i++) send(t_op[i], t_d[i], t_amt[i], 4'(i), t_exp[i]);
    fork
      begin
        for (int i = 3; i < 8; i++) send(t_op[i], t_d[i], t_amt[i], 4'(i), t_exp[i]);
      end
      begin
        out_ready = 1'b0;
        stall_chk = 1'b1;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (c == 1) begin
            chk("t5_full_in_ready", {31'h0, in_ready}, 32'd0);
            chk("t5_full_out_valid", {31'h0, out_valid}, 32'd1);
            chk("t5_held_count", q.size(), 32'd4);
          end
        end
        @(posedge clk);
        #1;
        stall_chk = 1'b0;
        out_ready = 1'b1;
      end
    join
    drain();

    // 6: reset with three operations held in flight
    out_ready = 1'b0;
    send(2'b00, 16'h0003, 4'd1, 4'hC, 16'h0006);
    send(2'b01, 16'h0030, 4'd4, 4'hD, 16'h0003);
    send(2'b11, 16'hF000, 4'd4, 4'hE, 16'h000F);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_before_valid", {31'h0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'h0, out_valid}, 32'd0);
    chk("t6_async_data",  {16'h0, out_data},  32'd0);
    q.delete();
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", {31'h0, in_ready}, 32'd1);
    repeat (10) @(negedge clk);
    chk("t6_no_output", {31'h0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
